// File: rtl/pio_irq_dispatcher.sv
// pio_irq_dispatcher
//
// Sequencer for a 32-bit edge-capture PIO. After reset it programs the PIO
// interrupt mask, then services each irq by reading the edge-capture
// register, clearing exactly the bits read, and offering the captured bits
// one at a time as event indices in round-robin order.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              permits new service cycles (sampled in IDLE only)
//   irq_in              PIO irq
//   m_address/m_chipselect/m_write_n/m_writedata/m_readdata
//                       Avalon-MM master to the PIO (readdata has one cycle
//                       of latency)
//   event_valid/event_ready/event_id
//                       valid/ready event stream to the consumer
//   event_ts            (PIO_IRQ_DISPATCH_TIMESTAMP_EN only) cycle stamp
//                       taken when the edge-capture readback is registered
//   busy                high whenever the FSM is not in IDLE
//
// Optional feature macro: PIO_IRQ_DISPATCH_TIMESTAMP_EN
//
// Every output is a register loaded from the decode of the next state, so
// the observable timing is that of a Moore machine decoded from the state
// register.

module pio_irq_dispatcher #(
    parameter logic [31:0] IRQ_MASK = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        irq_in,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [4:0]  event_id,
`ifdef PIO_IRQ_DISPATCH_TIMESTAMP_EN
    output logic [31:0] event_ts,
`endif
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned ID_W   = 5;

    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = ADDR_W'(3);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_RDW,
        ST_CLR,
        ST_DISP
    } state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   pending, pending_d;
    logic [DATA_W-1:0]   snap, snap_d;
    logic [ID_W-1:0]     rr_ptr, rr_d;
    logic [DATA_W-1:0]   readback_masked;
    logic                accept;

    logic                bus_cs_d;
    logic                bus_wn_d;
    logic [ADDR_W-1:0]   bus_addr_d;
    logic [DATA_W-1:0]   bus_wd_d;
    logic                ev_valid_d;
    logic [ID_W-1:0]     ev_id_d;

    // First set bit of vec searching upward from start, wrapping 31 -> 0.
    function automatic logic [ID_W-1:0] first_from(input logic [DATA_W-1:0] vec,
                                                   input logic [ID_W-1:0]   start);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] res;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            idx = start + ID_W'(i);
            if (!found && vec[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign readback_masked = m_readdata & IRQ_MASK;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_BOOT;
            pending <= '0;
            snap    <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_d;
            pending <= pending_d;
            snap    <= snap_d;
            rr_ptr  <= rr_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state;
        pending_d = pending;
        snap_d    = snap;
        rr_d      = rr_ptr;
        accept    = 1'b0;

        case (state)
            ST_BOOT: state_d = ST_INIT;
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (enable && irq_in) begin
                    state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_RDW;
            ST_RDW: begin
                // Readback is valid now; OR-ing merges re-captured bits.
                snap_d    = readback_masked;
                pending_d = pending | readback_masked;
                state_d   = ST_CLR;
            end
            ST_CLR:  state_d = ST_DISP;
            ST_DISP: begin
                accept = event_valid && event_ready;
                if (accept) begin
                    pending_d[event_id] = 1'b0;
                    rr_d                = event_id + ID_W'(1);
                end
                // Leave as soon as nothing remains, including on the last handshake.
                if (pending_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Output decode from the next state, registered below.
    always_comb begin
        bus_cs_d   = 1'b0;
        bus_wn_d   = 1'b1;
        bus_addr_d = '0;
        bus_wd_d   = '0;

        case (state_d)
            ST_INIT: begin
                bus_cs_d   = 1'b1;
                bus_wn_d   = 1'b0;
                bus_addr_d = ADDR_IRQMASK;
                bus_wd_d   = IRQ_MASK;
            end
            ST_RD: begin
                bus_cs_d   = 1'b1;
                bus_addr_d = ADDR_EDGECAP;
            end
            ST_CLR: begin
                bus_cs_d   = 1'b1;
                bus_wn_d   = 1'b0;
                bus_addr_d = ADDR_EDGECAP;
                bus_wd_d   = snap_d;
            end
            default: ;
        endcase

        ev_valid_d = (state_d == ST_DISP) && (pending_d != '0);
        ev_id_d    = ev_valid_d ? first_from(pending_d, rr_d) : '0;
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= '0;
            m_writedata  <= '0;
            event_valid  <= 1'b0;
            event_id     <= '0;
            busy         <= 1'b1;
        end else begin
            m_chipselect <= bus_cs_d;
            m_write_n    <= bus_wn_d;
            m_address    <= bus_addr_d;
            m_writedata  <= bus_wd_d;
            event_valid  <= ev_valid_d;
            event_id     <= ev_id_d;
            busy         <= (state_d != ST_IDLE);
        end
    end

`ifdef PIO_IRQ_DISPATCH_TIMESTAMP_EN
    logic [DATA_W-1:0] cycle_cnt;

    // Free-running cycle counter; its RDW value stamps the whole batch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            event_ts  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + DATA_W'(1);
            if (state == ST_RDW) begin
                event_ts <= cycle_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pio_irq_dispatcher.sv
// Directed bench for pio_irq_dispatcher. Two instances: index 0 with the
// default mask, index 1 with IRQ_MASK = 0x0000_00FF. Each is attached to a
// small edge-capture PIO model with registered readdata.

module tb_pio_irq_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n     = 1'b0;
    logic enable      = 1'b1;
    logic event_ready = 1'b1;

    logic [2:0]  m_address    [2];
    logic        m_chipselect [2];
    logic        m_write_n    [2];
    logic [31:0] m_writedata  [2];
    logic [31:0] m_readdata   [2];
    logic        event_valid  [2];
    logic [4:0]  event_id     [2];
    logic        busy         [2];
    logic        irq          [2];
`ifdef PIO_IRQ_DISPATCH_TIMESTAMP_EN
    logic [31:0] event_ts     [2];
`endif

    // PIO model state
    logic [31:0] cap      [2] = '{32'h0, 32'h0};
    logic [31:0] pio_mask [2] = '{32'h0, 32'h0};
    logic [31:0] inject   [2] = '{32'h0, 32'h0};
    int          wr_cnt   [2] = '{0, 0};
    int          rd_cnt   [2] = '{0, 0};
    int          acc_valid[2] = '{0, 0};
    logic [2:0]  last_wa  [2] = '{3'h0, 3'h0};
    logic [31:0] last_wd  [2] = '{32'h0, 32'h0};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] tb_cnt   = 32'h0;
    logic [31:0] ts_exp   = 32'h0;

    pio_irq_dispatcher u_dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .irq_in       (irq[0]),
        .m_address    (m_address[0]),
        .m_chipselect (m_chipselect[0]),
        .m_write_n    (m_write_n[0]),
        .m_writedata  (m_writedata[0]),
        .m_readdata   (m_readdata[0]),
        .event_valid  (event_valid[0]),
        .event_ready  (event_ready),
        .event_id     (event_id[0]),
`ifdef PIO_IRQ_DISPATCH_TIMESTAMP_EN
        .event_ts     (event_ts[0]),
`endif
        .busy         (busy[0])
    );

    pio_irq_dispatcher #(.IRQ_MASK(32'h0000_00FF)) u_dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (1'b1),
        .irq_in       (irq[1]),
        .m_address    (m_address[1]),
        .m_chipselect (m_chipselect[1]),
        .m_write_n    (m_write_n[1]),
        .m_writedata  (m_writedata[1]),
        .m_readdata   (m_readdata[1]),
        .event_valid  (event_valid[1]),
        .event_ready  (1'b1),
        .event_id     (event_id[1]),
`ifdef PIO_IRQ_DISPATCH_TIMESTAMP_EN
        .event_ts     (event_ts[1]),
`endif
        .busy         (busy[1])
    );

    assign irq[0] = |(cap[0] & pio_mask[0]);
    assign irq[1] = |(cap[1] & pio_mask[1]);

    // Edge-capture PIO: mask at address 2, write-1-to-clear capture at 3.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_chipselect[i]) begin
                if (!m_write_n[i]) begin
                    wr_cnt[i]  <= wr_cnt[i] + 1;
                    last_wa[i] <= m_address[i];
                    last_wd[i] <= m_writedata[i];
                    if (m_address[i] == 3'd2) pio_mask[i] <= m_writedata[i];
                end else begin
                    rd_cnt[i] <= rd_cnt[i] + 1;
                end
                if (event_valid[i]) acc_valid[i] <= acc_valid[i] + 1;
            end
            m_readdata[i] <= (m_chipselect[i] && m_write_n[i] && m_address[i] == 3'd3)
                             ? cap[i] : 32'h0;
            cap[i] <= (cap[i] & ~((m_chipselect[i] && !m_write_n[i] && m_address[i] == 3'd3)
                                  ? m_writedata[i] : 32'h0)) | inject[i];
        end
    end

    // Reference cycle counter, same reset as the DUT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cnt <= 32'h0;
        else          tb_cnt <= tb_cnt + 32'h1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Capture bits in PIO model i on the next edge (called at a negedge).
    task automatic pulse(input int i, input logic [31:0] bits);
        inject[i] = bits;
        cycle();
        inject[i] = 32'h0;
    endtask

    // Count edges until instance 0 offers an event; record the RDW stamp.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!event_valid[0] && n < 20) begin
            cycle();
            n++;
            if (n == 2) ts_exp = tb_cnt;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic expect_ev(input string tag, input logic [4:0] id);
        check({tag, "_valid"}, 32'(event_valid[0]), 32'h1);
        check({tag, "_id"}, 32'(event_id[0]), 32'(id));
        cycle();
    endtask

    task automatic end_batch(input string tag);
        check({tag, "_valid_low"}, 32'(event_valid[0]), 32'h0);
        check({tag, "_idle"}, 32'(busy[0]), 32'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"},    32'(m_chipselect[0]), 32'h0);
        check({tag, "_wn"},    32'(m_write_n[0]),    32'h1);
        check({tag, "_addr"},  32'(m_address[0]),    32'h0);
        check({tag, "_wd"},    m_writedata[0],       32'h0);
        check({tag, "_valid"}, 32'(event_valid[0]),  32'h0);
        check({tag, "_id"},    32'(event_id[0]),     32'h0);
        check({tag, "_busy"},  32'(busy[0]),         32'h1);
    endtask

    initial begin
        int wr0;
        int rd0;
        int acc0;

        // Reset and start-up
        repeat (3) cycle();
        check_reset_vals("rst");
        reset_n = 1'b1;
        cycle();
        check("init_cs",   32'(m_chipselect[0]), 32'h1);
        check("init_wn",   32'(m_write_n[0]),    32'h0);
        check("init_addr", 32'(m_address[0]),    32'h2);
        check("init_wd",   m_writedata[0],       32'hFFFF_FFFF);
        cycle();
        check("init_idle", 32'(busy[0]), 32'h0);
        check("init_bus_idle", 32'(m_chipselect[0]), 32'h0);
        repeat (5) cycle();
        check("init_wr_cnt", 32'(wr_cnt[0]), 32'h1);
        check("init_rd_cnt", 32'(rd_cnt[0]), 32'h0);
        check("init_mask1", pio_mask[1], 32'h0000_00FF);

        // Single edge on bit 5
        pulse(0, 32'h20);
        wait_valid("single", 4);
        check("single_rd_cnt", 32'(rd_cnt[0]), 32'h1);
        check("single_clr_addr", 32'(last_wa[0]), 32'h3);
        check("single_clr_data", last_wd[0], 32'h20);
`ifdef PIO_IRQ_DISPATCH_TIMESTAMP_EN
        check("single_ts", event_ts[0], ts_exp);
`endif
        expect_ev("single", 5'd5);
        end_batch("single");
        check("single_irq_low", 32'(irq[0]), 32'h0);

        // rr_ptr = 6: bits 4 and 7 give 7 first
        pulse(0, 32'h90);
        wait_valid("rr6", 4);
        expect_ev("rr6_a", 5'd7);
        expect_ev("rr6_b", 5'd4);
        end_batch("rr6");

        // id 31 wraps rr_ptr to 0, then 0, 4, 31 back to back
        pulse(0, 32'h8000_0000);
        wait_valid("wrap", 4);
        expect_ev("wrap", 5'd31);
        end_batch("wrap");
        pulse(0, 32'h8000_0011);
        wait_valid("rr0", 4);
        expect_ev("rr0_a", 5'd0);
        expect_ev("rr0_b", 5'd4);
        expect_ev("rr0_c", 5'd31);
        end_batch("rr0");

        // Back-pressure with id 3 pending
        event_ready = 1'b0;
        pulse(0, 32'h8);
        wait_valid("bp", 4);
        acc0 = acc_valid[0];
        wr0  = wr_cnt[0];
        rd0  = rd_cnt[0];
        for (int k = 0; k < 10; k++) begin
            check("bp_hold_valid", 32'(event_valid[0]), 32'h1);
            check("bp_hold_id", 32'(event_id[0]), 32'h3);
            cycle();
        end
        check("bp_no_access", 32'(wr_cnt[0] + rd_cnt[0]), 32'(wr0 + rd0));
        check("bp_acc_valid", 32'(acc_valid[0]), 32'(acc0));
        event_ready = 1'b1;
        cycle();
        end_batch("bp");

        // enable low blocks service; raising it lets the batch run
        enable = 1'b0;
        rd0 = rd_cnt[0];
        pulse(0, 32'h1);
        repeat (10) cycle();
        check("en_no_read", 32'(rd_cnt[0]), 32'(rd0));
        check("en_idle", 32'(busy[0]), 32'h0);
        enable = 1'b1;
        wait_valid("en", 4);
        expect_ev("en", 5'd0);
        end_batch("en");

        // Masking on instance 1: readback 0x102 with mask 0xFF
        pulse(1, 32'h102);
        repeat (4) cycle();
        check("mask_valid", 32'(event_valid[1]), 32'h1);
        check("mask_id", 32'(event_id[1]), 32'h1);
        check("mask_clr_data", last_wd[1], 32'h2);
        cycle();
        check("mask_valid_low", 32'(event_valid[1]), 32'h0);
        check("mask_idle", 32'(busy[1]), 32'h0);
        check("mask_cap_left", cap[1], 32'h100);

        // Reset while two events are pending (rr_ptr = 1 so id 1 first)
        event_ready = 1'b0;
        pulse(0, 32'h3);
        wait_valid("mid", 4);
        check("mid_id", 32'(event_id[0]), 32'h1);
        wr0 = wr_cnt[0];
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        cycle();
        reset_n = 1'b1;
        event_ready = 1'b1;
        repeat (3) cycle();
        check("reinit_wr_cnt", 32'(wr_cnt[0]), 32'(wr0 + 1));
        check("reinit_addr", 32'(last_wa[0]), 32'h2);
        check("reinit_data", last_wd[0], 32'hFFFF_FFFF);
        check("reinit_idle", 32'(busy[0]), 32'h0);
        // rr_ptr and pending cleared: bits 0,7 give 0 then 7 and nothing else
        pulse(0, 32'h81);
        wait_valid("post", 4);
`ifdef PIO_IRQ_DISPATCH_TIMESTAMP_EN
        check("post_ts", event_ts[0], ts_exp);
`endif
        expect_ev("post_a", 5'd0);
        expect_ev("post_b", 5'd7);
        end_batch("post");
        check("final_acc_valid", 32'(acc_valid[0]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
